// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: two read ports, one size-qualified write
// port and the busy flag raised during the post-reset clear sweep.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] rd_index_a;
  logic [ADDR_WIDTH-1:0] rd_index_b;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  wr_enable;
  logic [ADDR_WIDTH-1:0] wr_index;
  logic [1:0]            wr_size;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;

  // Decode/execute side drives indices and write data.
  modport master (
    output rd_index_a, rd_index_b, wr_enable, wr_index, wr_size, wr_data,
    input  rd_data_a, rd_data_b, busy
  );

  // Register file side.
  modport slave (
    input  rd_index_a, rd_index_b, wr_enable, wr_index, wr_size, wr_data,
    output rd_data_a, rd_data_b, busy
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: 2-read/1-write register file for the micro68k core.
// - 68000 size-qualified writes (.B/.W/.L) merge into the low bits of the
//   target register; size 2'b11 is a silent no-op.
// - After reset a clear sweep zeroes one register per cycle (DEPTH cycles);
//   busy is high and reads/writes are ignored while it runs.
// - Storage is split into byte lanes so a .B/.W write is a plain per-lane
//   write enable instead of a read-modify-write.
// Optional feature: define REGFILE_BYPASS_EN for write-first behaviour when a
// read index matches a valid same-cycle write; otherwise reads are read-first.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic              raw_clk,
  input  logic              reset,
  register_file_mp_if.slave rf
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  busy_reg, busy_next;

  logic                  clearing;
  logic                  rd_hold;
  logic                  wr_in_range;
  logic                  wr_valid;
  logic                  rd_a_in_range;
  logic                  rd_b_in_range;
  logic                  bypass_a;
  logic                  bypass_b;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] rd_a_word;
  logic [DATA_WIDTH-1:0] rd_b_word;

  // FSM state, sweep counter and busy flag; reset restarts the sweep.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state: sweep one index per cycle, drop busy on the edge that
  // clears the last register.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    case (state_reg)
      ST_CLEAR: begin
        busy_next = 1'b1;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_IDX) begin
          state_next = ST_READY;
          busy_next  = 1'b0;
          cnt_next   = '0;
        end
      end
      ST_READY: begin
        busy_next = 1'b0;
      end
      default: begin
        state_next = ST_CLEAR;
        busy_next  = 1'b1;
        cnt_next   = '0;
      end
    endcase
  end

  assign clearing      = (state_reg == ST_CLEAR) && !reset;
  assign rd_hold       = reset || (state_reg == ST_CLEAR);
  assign wr_in_range   = {1'b0, rf.wr_index} < DEPTH_W;
  assign rd_a_in_range = {1'b0, rf.rd_index_a} < DEPTH_W;
  assign rd_b_in_range = {1'b0, rf.rd_index_b} < DEPTH_W;
  assign wr_valid      = (state_reg == ST_READY) && !reset && rf.wr_enable &&
                         (rf.wr_size != 2'b11) && wr_in_range;
  assign mem_addr      = clearing ? cnt_reg : rf.wr_index;

`ifdef REGFILE_BYPASS_EN
  // Write-first: a matching read sees the merged post-write value.
  assign bypass_a = wr_valid && (rf.rd_index_a == rf.wr_index);
  assign bypass_b = wr_valid && (rf.rd_index_b == rf.wr_index);
`else
  // Read-first: the array read already returns the pre-write value.
  assign bypass_a = 1'b0;
  assign bypass_b = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      // Lane 0 is written by every size, lane 1 by .W/.L, upper lanes by .L.
      localparam bit IN_WORD = (gi < 2);
      localparam bit IN_BYTE = (gi == 0);

      logic [7:0] mem_reg [DEPTH];
      logic [7:0] rd_a_reg;
      logic [7:0] rd_b_reg;
      logic       lane_sel;
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign lane_sel   = IN_BYTE || (rf.wr_size == 2'b10) ||
                          (IN_WORD && (rf.wr_size == 2'b01));
      assign lane_we    = clearing || (wr_valid && lane_sel);
      assign lane_wdata = clearing ? 8'h00 : rf.wr_data[gi*8 +: 8];

      // Lane storage write: sweep zeroes or size-selected write data.
      always_ff @(posedge raw_clk) begin
        if (lane_we) begin
          mem_reg[mem_addr] <= lane_wdata;
        end
      end

      // Registered read port A; held at zero during reset/sweep.
      always_ff @(posedge raw_clk) begin
        if (rd_hold || !rd_a_in_range) begin
          rd_a_reg <= 8'h00;
        end else if (bypass_a && lane_sel) begin
          rd_a_reg <= rf.wr_data[gi*8 +: 8];
        end else begin
          rd_a_reg <= mem_reg[rf.rd_index_a];
        end
      end

      // Registered read port B; same rules as port A.
      always_ff @(posedge raw_clk) begin
        if (rd_hold || !rd_b_in_range) begin
          rd_b_reg <= 8'h00;
        end else if (bypass_b && lane_sel) begin
          rd_b_reg <= rf.wr_data[gi*8 +: 8];
        end else begin
          rd_b_reg <= mem_reg[rf.rd_index_b];
        end
      end

      assign rd_a_word[gi*8 +: 8] = rd_a_reg;
      assign rd_b_word[gi*8 +: 8] = rd_b_reg;
    end
  endgenerate

  assign rf.rd_data_a = rd_a_word;
  assign rf.rd_data_b = rd_b_word;
  assign rf.busy      = busy_reg;

endmodule

// File: tb/tb_register_file_mp.sv
// Testbench for register_file_mp: directed scenarios followed by random
// traffic, all compared against a word-level reference model each cycle.
module tb_register_file_mp;

  localparam int DEPTH = 16;

  logic raw_clk = 1'b0;
  logic reset   = 1'b1;

  always #5 raw_clk = ~raw_clk;

  register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) rf ();

  register_file_mp #(
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(4)
  ) dut (
    .raw_clk(raw_clk),
    .reset  (reset),
    .rf     (rf)
  );

  logic [31:0] model [DEPTH];
  int          sweep_left = 0;
  int          checks     = 0;
  int          errors     = 0;
  string       tag        = "init";

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [31:0] model_read(input logic [3:0] idx);
    if (int'(idx) < DEPTH) return model[idx];
    return 32'h0;
  endfunction

  task automatic check32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%h expected=%h", tag, name, obs, exp);
    end
  endtask

  // One clock: predict outputs from the model, advance, compare.
  task automatic cycle();
    logic        hold;
    logic        wv;
    logic [31:0] mask;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_busy;
    hold = reset || (sweep_left > 0);
    wv   = !hold && rf.wr_enable && (rf.wr_size != 2'b11) && (int'(rf.wr_index) < DEPTH);
    case (rf.wr_size)
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    if (wv && BYPASS)
      model[rf.wr_index] = (model[rf.wr_index] & ~mask) | (rf.wr_data & mask);
    exp_a = hold ? 32'h0 : model_read(rf.rd_index_a);
    exp_b = hold ? 32'h0 : model_read(rf.rd_index_b);
    if (wv && !BYPASS)
      model[rf.wr_index] = (model[rf.wr_index] & ~mask) | (rf.wr_data & mask);
    if (reset) begin
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end
    exp_busy = (sweep_left > 0);
    @(posedge raw_clk);
    #1;
    check32("busy", {31'h0, rf.busy}, {31'h0, exp_busy});
    check32("rd_a", rf.rd_data_a, exp_a);
    check32("rd_b", rf.rd_data_b, exp_b);
    $display("cyc rst=%0b we=%0b wi=%0d sz=%0d wd=%h ra=%0d rb=%0d -> busy=%0b a=%h b=%h",
             reset, rf.wr_enable, rf.wr_index, rf.wr_size, rf.wr_data,
             rf.rd_index_a, rf.rd_index_b, rf.busy, rf.rd_data_a, rf.rd_data_b);
  endtask

  task automatic drive(input logic we, input logic [3:0] wi, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    rf.wr_enable  = we;
    rf.wr_index   = wi;
    rf.wr_size    = sz;
    rf.wr_data    = wd;
    rf.rd_index_a = ra;
    rf.rd_index_b = rb;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 2'b10, 32'h0, 4'(i), 4'(i + 1));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'hx;
    rf.wr_enable = 1'b0; rf.wr_index = '0; rf.wr_size = 2'b10;
    rf.wr_data = '0; rf.rd_index_a = '0; rf.rd_index_b = '0;

    // 1) reset, 16-cycle sweep, then every register reads zero
    tag = "t1_reset";
    reset = 1'b1;
    idle(1);
    check32("busy_after_reset", {31'h0, rf.busy}, 32'h1);
    reset = 1'b0;
    tag = "t1_sweep";
    idle(15);
    check32("busy_cycle15", {31'h0, rf.busy}, 32'h1);
    idle(1);
    check32("busy_cycle16", {31'h0, rf.busy}, 32'h0);
    tag = "t1_readall";
    for (int i = 0; i < DEPTH; i += 2) begin
      drive(1'b0, 4'd0, 2'b10, 32'h0, 4'(i), 4'(i + 1));
      check32("zero_a", rf.rd_data_a, 32'h0);
      check32("zero_b", rf.rd_data_b, 32'h0);
    end

    // 2) long write then read on the next cycle
    tag = "t2_long";
    drive(1'b1, 4'd3, 2'b10, 32'h1234_5678, 4'd0, 4'd1);
    drive(1'b0, 4'd0, 2'b10, 32'h0, 4'd3, 4'd2);
    check32("r3_long", rf.rd_data_a, 32'h1234_5678);

    // 3) byte / word / reserved merges
    tag = "t3_byte";
    drive(1'b1, 4'd3, 2'b00, 32'hAABB_CCDD, 4'd0, 4'd0);
    drive(1'b0, 4'd0, 2'b10, 32'h0, 4'd3, 4'd3);
    check32("r3_byte", rf.rd_data_a, 32'h1234_56DD);
    tag = "t3_word";
    drive(1'b1, 4'd3, 2'b01, 32'h0000_BEEF, 4'd0, 4'd0);
    drive(1'b0, 4'd0, 2'b10, 32'h0, 4'd3, 4'd3);
    check32("r3_word", rf.rd_data_b, 32'h1234_BEEF);
    tag = "t3_rsvd";
    drive(1'b1, 4'd3, 2'b11, 32'hFFFF_FFFF, 4'd0, 4'd0);
    drive(1'b0, 4'd0, 2'b10, 32'h0, 4'd3, 4'd3);
    check32("r3_rsvd", rf.rd_data_a, 32'h1234_BEEF);

    // 4) same-cycle write and read of R5
    tag = "t4_collide";
    drive(1'b1, 4'd5, 2'b10, 32'hCAFE_F00D, 4'd5, 4'd5);
    check32("r5_a_same", rf.rd_data_a, BYPASS ? 32'hCAFE_F00D : 32'h0);
    check32("r5_b_same", rf.rd_data_b, BYPASS ? 32'hCAFE_F00D : 32'h0);
    drive(1'b0, 4'd0, 2'b10, 32'h0, 4'd5, 4'd5);
    check32("r5_next", rf.rd_data_a, 32'hCAFE_F00D);

    // 5) write attempt during sweep cycle 4 is dropped
    tag = "t5_busywr";
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(3);
    drive(1'b1, 4'd7, 2'b10, 32'hFFFF_FFFF, 4'd7, 4'd7);
    check32("rd_during_sweep", rf.rd_data_a, 32'h0);
    idle(12);
    check32("busy_done", {31'h0, rf.busy}, 32'h0);
    drive(1'b0, 4'd0, 2'b10, 32'h0, 4'd7, 4'd5);
    check32("r7_zero", rf.rd_data_a, 32'h0);
    check32("r5_cleared", rf.rd_data_b, 32'h0);

    // 6) reset mid-sweep restarts the full sweep
    tag = "t6_restart";
    drive(1'b1, 4'd0, 2'b10, 32'hDEAD_BEEF, 4'd1, 4'd1);
    drive(1'b0, 4'd0, 2'b10, 32'h0, 4'd0, 4'd0);
    check32("r0_preload", rf.rd_data_a, 32'hDEAD_BEEF);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(7);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(15);
    check32("busy_restart15", {31'h0, rf.busy}, 32'h1);
    idle(1);
    check32("busy_restart16", {31'h0, rf.busy}, 32'h0);
    for (int i = 0; i < DEPTH; i += 2) begin
      drive(1'b0, 4'd0, 2'b10, 32'h0, 4'(i), 4'(i + 1));
      check32("restart_zero_a", rf.rd_data_a, 32'h0);
      check32("restart_zero_b", rf.rd_data_b, 32'h0);
    end

    // 7) random traffic against the model
    tag = "t7_random";
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wi;
      logic [3:0] ra;
      logic [3:0] rb;
      wi = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wi : 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? wi : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), wi, 2'($urandom_range(0, 3)), $urandom, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
